// File: rtl/bird_motion_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bird_motion_pkg
// Shared types and constants for the bird motion sequencer.
//   state_t          : sequencer states
//   ADDR_*           : Avalon-MM word addresses of the register map
//   CTRL_*_BIT       : bit positions inside the CTRL register (write and read)
//   is_running()     : true while the bird is in flight
// -----------------------------------------------------------------------------
package bird_motion_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    VEL  = 3'd2,
    POS  = 3'd3,
    DEAD = 3'd4
  } state_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_GRAVITY = 2'd1;
  localparam logic [1:0] ADDR_FLAP    = 2'd2;
  localparam logic [1:0] ADDR_POS     = 2'd3;

  // CTRL write bits
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  // CTRL read bits (irq_en shares bit 1 with the write layout)
  localparam int CTRL_RUN_BIT    = 0;
  localparam int CTRL_DEAD_BIT   = 2;

  function automatic logic is_running(input state_t s);
    return (s != IDLE) && (s != DEAD);
  endfunction

endpackage

// File: rtl/bird_motion_ctrl_edge.sv
// -----------------------------------------------------------------------------
// rise_edge_det
// One-bit rising-edge detector. The previous input level is registered; the
// pulse is high for the single cycle in which the input is high and the
// registered copy is still low. The input is expected to be synchronous.
//   clk     in  system clock
//   reset   in  asynchronous active-high reset
//   i_d     in  level input
//   o_rise  out one-cycle pulse on a 0->1 transition of i_d
// -----------------------------------------------------------------------------
module rise_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_d;
    end
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/bird_motion_ctrl.sv
// -----------------------------------------------------------------------------
// bird_motion_ctrl
// Per-frame sequencer for the bird sprite. Each frame_tick applies gravity or
// a flap impulse to a signed velocity, integrates it into bird_y and clamps at
// ceiling and floor. Floor contact kills the bird and can raise an interrupt.
// Configured by the Nios through a 4-word Avalon-MM slave.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   frame_tick   in   one-cycle pulse per video frame
//   flap         in   synchronised flap button (level)
//   address      in   Avalon word address
//   chipselect   in   Avalon select
//   write_n      in   Avalon write strobe, active low
//   writedata    in   Avalon write data
//   readdata     out  Avalon read data, combinational from address
//   bird_x       out  constant X_START
//   bird_y       out  current vertical position
//   alive        out  high in RUN/VEL/POS
//   irq          out  dead interrupt (level)
//
// Register map
//   0 CTRL     W: bit0 start, bit1 irq_en   R: {dead, irq_en, running}
//   1 GRAVITY  signed VEL_W, read sign-extended
//   2 FLAP_VEL signed VEL_W, read sign-extended
//   3 POS      R: {bird_y, bird_x}   W: clears dead and irq
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for a start write
// RUN   | in flight, waiting for frame_tick
// VEL   | update velocity (flap impulse or saturated gravity add)
// POS   | integrate velocity into bird_y, clamp, detect floor hit
// DEAD  | bird on the floor, position frozen until the next start
// -----------------------------------------------------------------------------
module bird_motion_ctrl
  import bird_motion_pkg::*;
#(
  parameter int POS_W        = 16,
  parameter int VEL_W        = 12,
  parameter int X_START      = 100,
  parameter int Y_START      = 240,
  parameter int CEIL_Y       = 0,
  parameter int FLOOR_Y      = 440,
  parameter int MAX_VEL      = 15,
  parameter int G_DEFAULT    = 1,
  parameter int FLAP_DEFAULT = -8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             flap,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [POS_W-1:0] bird_x,
  output logic [POS_W-1:0] bird_y,
  output logic             alive,
  output logic             irq
);

  localparam logic [POS_W-1:0]        X_POS   = POS_W'(X_START);
  localparam logic [POS_W-1:0]        Y_INIT  = POS_W'(Y_START);
  localparam logic [POS_W-1:0]        Y_CEIL  = POS_W'(CEIL_Y);
  localparam logic [POS_W-1:0]        Y_FLOOR = POS_W'(FLOOR_Y);
  localparam logic signed [POS_W:0]   CEIL_S  = (POS_W+1)'(CEIL_Y);
  localparam logic signed [POS_W:0]   FLOOR_S = (POS_W+1)'(FLOOR_Y);
  localparam logic signed [VEL_W:0]   VEL_MAX = (VEL_W+1)'(MAX_VEL);
  localparam logic signed [VEL_W:0]   VEL_MIN = -VEL_MAX;

  state_t                  r_state;
  logic signed [VEL_W-1:0] r_vel;
  logic signed [VEL_W-1:0] r_gravity;
  logic signed [VEL_W-1:0] r_flap_vel;
  logic [POS_W-1:0]        r_bird_y;
  logic                    r_alive;
  logic                    r_irq;
  logic                    r_dead;
  logic                    r_irq_en;
  logic                    r_flap_pending;

  logic                    w_wr;
  logic                    w_start;
  logic                    w_pos_wr;
  logic                    w_flap_rise;
  logic signed [VEL_W:0]   w_vel_sum;
  logic signed [VEL_W-1:0] w_vel_sat;
  logic signed [POS_W:0]   w_vel_ext;
  logic signed [POS_W:0]   w_y_next;
  logic                    w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_start  = w_wr && (address == ADDR_CTRL) && writedata[CTRL_START_BIT];
  assign w_pos_wr = w_wr && (address == ADDR_POS);
  assign w_unused = ^writedata[31:VEL_W];

  rise_edge_det u_flap_edge (
    .clk    (clk),
    .reset  (reset),
    .i_d    (flap),
    .o_rise (w_flap_rise)
  );

  // One extra bit on the add so the saturation compare never sees a wrapped sum.
  assign w_vel_sum = {r_vel[VEL_W-1], r_vel} + {r_gravity[VEL_W-1], r_gravity};

  always_comb begin
    w_vel_sat = w_vel_sum[VEL_W-1:0];
    if (w_vel_sum > VEL_MAX) begin
      w_vel_sat = VEL_MAX[VEL_W-1:0];
    end else if (w_vel_sum < VEL_MIN) begin
      w_vel_sat = VEL_MIN[VEL_W-1:0];
    end
  end

  // Position is unsigned; widen by one bit so moves above the ceiling go negative.
  assign w_vel_ext = {{(POS_W + 1 - VEL_W){r_vel[VEL_W-1]}}, r_vel};
  assign w_y_next  = {1'b0, r_bird_y} + w_vel_ext;

  // Configuration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gravity  <= VEL_W'(G_DEFAULT);
      r_flap_vel <= VEL_W'(FLAP_DEFAULT);
      r_irq_en   <= 1'b0;
    end else if (w_wr) begin
      case (address)
        ADDR_CTRL:    r_irq_en   <= writedata[CTRL_IRQ_EN_BIT];
        ADDR_GRAVITY: r_gravity  <= writedata[VEL_W-1:0];
        ADDR_FLAP:    r_flap_vel <= writedata[VEL_W-1:0];
        default:      ;
      endcase
    end
  end

  // Sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_vel          <= '0;
      r_bird_y       <= Y_INIT;
      r_alive        <= 1'b0;
      r_irq          <= 1'b0;
      r_dead         <= 1'b0;
      r_flap_pending <= 1'b0;
    end else begin
      r_irq <= r_dead & r_irq_en;

      if (w_start) begin
        // Start wins over everything, including a same-cycle frame_tick.
        r_state        <= RUN;
        r_alive        <= 1'b1;
        r_bird_y       <= Y_INIT;
        r_vel          <= '0;
        r_flap_pending <= 1'b0;
        r_dead         <= 1'b0;
        r_irq          <= 1'b0;
      end else begin
        if (w_pos_wr) begin
          r_dead <= 1'b0;
          r_irq  <= 1'b0;
        end

        case (r_state)
          IDLE: ;

          RUN: begin
            if (w_flap_rise) begin
              r_flap_pending <= 1'b1;
            end
            if (frame_tick) begin
              r_state <= VEL;
            end
          end

          VEL: begin
            r_vel <= r_flap_pending ? r_flap_vel : w_vel_sat;
            // An edge arriving while the old request is consumed carries over.
            r_flap_pending <= w_flap_rise;
            r_state        <= POS;
          end

          POS: begin
            if (w_flap_rise) begin
              r_flap_pending <= 1'b1;
            end
            if (w_y_next >= FLOOR_S) begin
              r_bird_y <= Y_FLOOR;
              r_vel    <= '0;
              r_dead   <= 1'b1;
              r_alive  <= 1'b0;
              r_state  <= DEAD;
            end else if (w_y_next < CEIL_S) begin
              r_bird_y <= Y_CEIL;
              r_vel    <= '0;
              r_state  <= RUN;
            end else begin
              r_bird_y <= w_y_next[POS_W-1:0];
              r_state  <= RUN;
            end
          end

          DEAD: ;

          default: begin
            r_state <= IDLE;
            r_alive <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_RUN_BIT]    = is_running(r_state);
        readdata[CTRL_IRQ_EN_BIT] = r_irq_en;
        readdata[CTRL_DEAD_BIT]   = r_dead;
      end
      ADDR_GRAVITY: readdata = {{(32 - VEL_W){r_gravity[VEL_W-1]}}, r_gravity};
      ADDR_FLAP:    readdata = {{(32 - VEL_W){r_flap_vel[VEL_W-1]}}, r_flap_vel};
      ADDR_POS:     readdata = 32'({r_bird_y, X_POS});
      default:      readdata = '0;
    endcase
  end

  assign bird_x = X_POS;
  assign bird_y = r_bird_y;
  assign alive  = r_alive;
  assign irq    = r_irq;

endmodule
